// File: rtl/ntsc_sync_sep.sv
`default_nettype none
// ============================================================================
// Module   : ntsc_sync_sep
// Purpose  : Composite-video sync separator with a flywheel line timer.
//            It takes 10-bit composite samples, one per CK_EE_i strobe, and
//            classifies each sync-level pulse by width as H-sync, equalizing,
//            broad, or ignored. It then keeps a horizontal/vertical position
//            that locks to the incoming line rate.
// Ports    : CK_i       clock, runs at 8x the sample rate
//            XARST_i    synchronous reset, active low
//            CK_EE_i    sample strobe; all state advances only on strobe cycles
//            VIDEOs_i   composite sample, valid while CK_EE_i = 1
//            HSYNC_o    1-cycle pulse at the end of an accepted H-sync
//            VSYNC_o    1-cycle pulse at the end of the 3rd consecutive broad
//            FIELD_o    0 = field 1, 1 = field 2
//            LOCKED_o   flywheel locked to the incoming line timing
//            HCTRs_o    sample index within the line, 0..C_H_TOTAL-1
//            VCTRs_o    line index since the last VSYNC, saturates at 1023
// Revision : 1.0  initial release
// ============================================================================
module ntsc_sync_sep #(
    parameter logic [9:0] C_SYNC_TH = 10'd64,
    parameter int         C_H_TOTAL = 780,
    parameter int         C_HS_MIN  = 48,
    parameter int         C_HS_MAX  = 70,
    parameter int         C_EQ_MIN  = 20,
    parameter int         C_EQ_MAX  = 40,
    parameter int         C_BR_MIN  = 280,
    parameter int         C_H_TOL   = 4,
    parameter int         C_LOCK_N  = 4
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       CK_EE_i,
    input  logic [9:0] VIDEOs_i,
    output logic       HSYNC_o,
    output logic       VSYNC_o,
    output logic       FIELD_o,
    output logic       LOCKED_o,
    output logic [9:0] HCTRs_o,
    output logic [9:0] VCTRs_o
);

    localparam logic [0:0] S_HUNT = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [9:0] C_HCTR_LAST = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] C_HALF_LINE = 10'(C_H_TOTAL / 2);
    localparam logic [9:0] C_HS_MIN_W  = 10'(C_HS_MIN);
    localparam logic [9:0] C_HS_MAX_W  = 10'(C_HS_MAX);
    localparam logic [9:0] C_EQ_MIN_W  = 10'(C_EQ_MIN);
    localparam logic [9:0] C_EQ_MAX_W  = 10'(C_EQ_MAX);
    localparam logic [9:0] C_BR_MIN_W  = 10'(C_BR_MIN);
    localparam logic [9:0] C_TOL_W     = 10'(C_H_TOL);
    localparam logic [2:0] C_LOCK_CNT  = 3'(C_LOCK_N);
    // Lines 0..8 after VSYNC are the vertical interval; no H pulses are
    // expected there, so missing ones must not count against lock.
    localparam logic [9:0] C_VBLANK    = 10'd9;
    localparam logic [9:0] C_SAT       = 10'h3FF;

    logic [0:0] r_state;
    logic       r_sync_f;
    logic       r_diff;
    logic [9:0] r_width;
    logic [9:0] r_hctr;
    logic [9:0] r_vctr;
    logic [2:0] r_good;
    logic [2:0] r_miss;
    logic [1:0] r_brcnt;
    logic       r_seen;

    logic       w_raw;
    logic       w_toggle;
    logic       w_rise;
    logic       w_fall;
    logic [9:0] w_width_inc;
    logic       w_is_h;
    logic       w_is_eq;
    logic       w_is_br;
    logic       w_is_ign;
    logic       w_wrap;
    logic [9:0] w_hctr_inc;
    logic [9:0] w_vctr_inc;
    logic [9:0] w_phase_err;
    logic       w_in_win;
    logic       w_missed;

    assign HCTRs_o = r_hctr;
    assign VCTRs_o = r_vctr;

    // Sync level is accepted only after two consecutive disagreeing samples.
    assign w_raw    = (VIDEOs_i < C_SYNC_TH);
    assign w_toggle = (w_raw != r_sync_f) && r_diff;
    assign w_rise   = w_toggle && !r_sync_f;
    assign w_fall   = w_toggle && r_sync_f;

    // The closing sample of a pulse still counts toward its width, so the
    // width is classified from the incremented value.
    assign w_width_inc = (r_width == C_SAT) ? r_width : r_width + 10'd1;

    assign w_is_h   = w_fall && (w_width_inc >= C_HS_MIN_W) && (w_width_inc <= C_HS_MAX_W);
    assign w_is_eq  = w_fall && (w_width_inc >= C_EQ_MIN_W) && (w_width_inc <= C_EQ_MAX_W);
    assign w_is_br  = w_fall && (w_width_inc >= C_BR_MIN_W);
    assign w_is_ign = w_fall && !(w_is_h || w_is_eq || w_is_br);

    assign w_wrap     = (r_hctr == C_HCTR_LAST);
    assign w_hctr_inc = w_wrap ? 10'd0 : r_hctr + 10'd1;
    assign w_vctr_inc = (r_vctr == C_SAT) ? r_vctr : r_vctr + 10'd1;

    // Reloading HCTR with the pulse width places HCTR = 0 on the sync leading
    // edge; the flywheel agrees when its next value is close to that width.
    assign w_phase_err = (w_hctr_inc >= w_width_inc) ? (w_hctr_inc - w_width_inc)
                                                     : (w_width_inc - w_hctr_inc);
    assign w_in_win    = w_is_h && (w_phase_err <= C_TOL_W);

    // A line ends with no in-window H since the previous wrap.
    assign w_missed = w_wrap && !(r_seen || w_in_win) && (r_vctr >= C_VBLANK);

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            r_state  <= S_HUNT;
            r_sync_f <= 1'b0;
            r_diff   <= 1'b0;
            r_width  <= 10'd0;
            r_hctr   <= 10'd0;
            r_vctr   <= 10'd0;
            r_good   <= 3'd0;
            r_miss   <= 3'd0;
            r_brcnt  <= 2'd0;
            r_seen   <= 1'b0;
            HSYNC_o  <= 1'b0;
            VSYNC_o  <= 1'b0;
            FIELD_o  <= 1'b0;
            LOCKED_o <= 1'b0;
        end else begin
            HSYNC_o <= 1'b0;
            VSYNC_o <= 1'b0;
            if (CK_EE_i) begin
                if (w_raw == r_sync_f) begin
                    r_diff <= 1'b0;
                end else if (r_diff) begin
                    r_sync_f <= w_raw;
                    r_diff   <= 1'b0;
                end else begin
                    r_diff <= 1'b1;
                end

                if (w_rise) begin
                    r_width <= 10'd0;
                end else if (r_sync_f) begin
                    r_width <= w_width_inc;
                end

                // Free-running flywheel; an accepted H reload below overrides
                // the increment, while the line count still advances on wrap.
                r_hctr <= w_hctr_inc;
                if (w_wrap) begin
                    r_vctr <= w_vctr_inc;
                end

                if (w_in_win) begin
                    r_seen <= 1'b1;
                end else if (w_wrap) begin
                    r_seen <= 1'b0;
                end

                case (r_state)
                    S_HUNT: begin
                        if (w_is_h) begin
                            r_hctr  <= w_width_inc;
                            HSYNC_o <= 1'b1;
                            if (!w_in_win) begin
                                r_good <= 3'd0;
                            end else if (r_good == C_LOCK_CNT - 3'd1) begin
                                r_state  <= S_LOCK;
                                LOCKED_o <= 1'b1;
                                r_good   <= 3'd0;
                                r_miss   <= 3'd0;
                            end else begin
                                r_good <= r_good + 3'd1;
                            end
                        end
                    end
                    S_LOCK: begin
                        if (w_in_win) begin
                            r_hctr  <= w_width_inc;
                            HSYNC_o <= 1'b1;
                            r_miss  <= 3'd0;
                        end else if (w_missed) begin
                            if (r_miss == C_LOCK_CNT - 3'd1) begin
                                r_state  <= S_HUNT;
                                LOCKED_o <= 1'b0;
                                r_good   <= 3'd0;
                                r_miss   <= 3'd0;
                            end else begin
                                r_miss <= r_miss + 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_HUNT;
                        LOCKED_o <= 1'b0;
                    end
                endcase

                // Vertical: three broad pulses in a row mark VSYNC; EQ pulses
                // are transparent, anything else breaks the run.
                if (w_is_br) begin
                    if (r_brcnt == 2'd2) begin
                        VSYNC_o <= 1'b1;
                        r_brcnt <= 2'd0;
                        r_vctr  <= 10'd0;
                        FIELD_o <= (r_hctr >= C_HALF_LINE);
                    end else begin
                        r_brcnt <= r_brcnt + 2'd1;
                    end
                end else if (w_is_h || w_is_ign) begin
                    r_brcnt <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntsc_sync_sep.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntsc_sync_sep
// Purpose  : Self-checking bench for ntsc_sync_sep. Line-train vectors with
//            expected HSYNC/lock per line, hand-built vertical, spike and
//            reset sequences, and randomized lines compared sample by sample
//            against a behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ntsc_sync_sep;

    logic       r_clk   = 1'b0;
    logic       r_xarst = 1'b0;
    logic       r_ck_ee = 1'b0;
    logic [9:0] r_video = 10'd0;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_field;
    logic       w_locked;
    logic [9:0] w_hctr;
    logic [9:0] w_vctr;

    ntsc_sync_sep dut (
        .CK_i     (r_clk),
        .XARST_i  (r_xarst),
        .CK_EE_i  (r_ck_ee),
        .VIDEOs_i (r_video),
        .HSYNC_o  (w_hsync),
        .VSYNC_o  (w_vsync),
        .FIELD_o  (w_field),
        .LOCKED_o (w_locked),
        .HCTRs_o  (w_hctr),
        .VCTRs_o  (w_vctr)
    );

    always #5 r_clk = ~r_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (per accepted sample) ----------------
    int m_hctr, m_vctr, m_width, m_good, m_miss, m_brcnt;
    bit m_sf, m_prev_raw, m_locked, m_seen, m_field, m_hs, m_vs;

    task automatic model_reset();
        m_hctr = 0; m_vctr = 0; m_width = 0; m_good = 0; m_miss = 0; m_brcnt = 0;
        m_sf = 0; m_prev_raw = 0; m_locked = 0; m_seen = 0; m_field = 0;
        m_hs = 0; m_vs = 0;
    endtask

    task automatic model_step(input logic [9:0] v);
        bit raw, old_sf, fall, is_h, is_eq, is_br, ign, in_win, wrap, missed;
        int w, next_h, next_v, err;
        raw    = (v < 10'd64);
        old_sf = m_sf;
        fall   = 0;
        m_hs   = 0;
        m_vs   = 0;
        if (old_sf) m_width = (m_width + 1 > 1023) ? 1023 : m_width + 1;
        // level accepted when this sample and the previous both disagree
        if (raw != old_sf && m_prev_raw != old_sf) begin
            m_sf = raw;
            if (raw) m_width = 0;
            else     fall = 1;
        end
        m_prev_raw = raw;

        w      = m_width;
        is_h   = fall && w >= 48 && w <= 70;
        is_eq  = fall && w >= 20 && w <= 40;
        is_br  = fall && w >= 280;
        ign    = fall && !is_h && !is_eq && !is_br;
        wrap   = (m_hctr == 779);
        next_h = (m_hctr + 1) % 780;
        next_v = wrap ? ((m_vctr + 1 > 1023) ? 1023 : m_vctr + 1) : m_vctr;
        err    = (next_h > w) ? next_h - w : w - next_h;
        in_win = is_h && err <= 4;
        missed = wrap && !m_seen && !in_win && m_vctr >= 9;

        if (!m_locked) begin
            if (is_h) begin
                next_h = w;
                m_hs   = 1;
                m_good = in_win ? m_good + 1 : 0;
                if (m_good == 4) begin m_locked = 1; m_good = 0; m_miss = 0; end
            end
        end else if (in_win) begin
            next_h = w;
            m_hs   = 1;
            m_miss = 0;
        end else if (missed) begin
            m_miss++;
            if (m_miss == 4) begin m_locked = 0; m_good = 0; m_miss = 0; end
        end
        m_seen = in_win ? 1'b1 : (wrap ? 1'b0 : m_seen);

        if (is_br) begin
            if (m_brcnt == 2) begin
                m_vs = 1; m_brcnt = 0; next_v = 0; m_field = (m_hctr >= 390);
            end else begin
                m_brcnt++;
            end
        end else if (is_h || ign) begin
            m_brcnt = 0;
        end
        m_hctr = next_h;
        m_vctr = next_v;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_outputs(input string name, input bit strobe);
        bit e_hs, e_vs;
        e_hs = strobe ? m_hs : 1'b0;
        e_vs = strobe ? m_vs : 1'b0;
        n_checks++;
        if (w_hsync !== e_hs || w_vsync !== e_vs || w_field !== m_field ||
            w_locked !== m_locked || w_hctr !== 10'(m_hctr) || w_vctr !== 10'(m_vctr)) begin
            n_fail++;
            $display("FAIL %s @%0t: got hs=%0d vs=%0d field=%0d lock=%0d hctr=%0d vctr=%0d, expected hs=%0d vs=%0d field=%0d lock=%0d hctr=%0d vctr=%0d",
                     name, $time, w_hsync, w_vsync, w_field, w_locked, w_hctr, w_vctr,
                     e_hs, e_vs, m_field, m_locked, m_hctr, m_vctr);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- observation of DUT pulses ----------------
    int hs_cnt, hs_hctr, vs_cnt, vs_first_seg, vs_first_field, vs_first_vctr, cur_seg;
    bit noisy = 0;

    task automatic clear_obs();
        hs_cnt = 0; hs_hctr = 1023; vs_cnt = 0;
        vs_first_seg = -1; vs_first_field = -1; vs_first_vctr = -1;
    endtask

    // One accepted sample, followed by occasional idle (non-strobe) cycles.
    task automatic step(input logic [9:0] v);
        int gap;
        r_video = v;
        r_ck_ee = 1'b1;
        @(negedge r_clk);
        model_step(v);
        r_ck_ee = 1'b0;
        r_video = 10'($urandom_range(0, 1023));
        check_outputs("sample", 1'b1);
        if (w_hsync) begin hs_cnt++; hs_hctr = int'(w_hctr); end
        if (w_vsync) begin
            if (vs_cnt == 0) begin
                vs_first_seg = cur_seg; vs_first_field = int'(w_field); vs_first_vctr = int'(w_vctr);
            end
            vs_cnt++;
        end
        gap = ($urandom_range(0, 31) == 0) ? 7 : 0;
        repeat (gap) begin
            @(negedge r_clk);
            check_outputs("idle", 1'b0);
        end
    endtask

    function automatic logic [9:0] sync_lvl();
        return 10'($urandom_range(0, 63));
    endfunction

    function automatic logic [9:0] blank_lvl();
        return 10'($urandom_range(100, 1023));
    endfunction

    // w samples at sync level, then blanking up to len samples.
    task automatic send_line(input int w, input int len);
        bit last_spike;
        last_spike = 0;
        for (int i = 0; i < len; i++) begin
            if (i < w) begin
                step(sync_lvl());
            end else if (noisy && !last_spike && i > w + 3 && i < len - 3 &&
                         $urandom_range(0, 63) == 0) begin
                last_spike = 1;
                step(sync_lvl());
            end else begin
                last_spike = 0;
                step(blank_lvl());
            end
        end
    endtask

    // Isolated 1-sample spikes plus one pulse of width pw starting at 500.
    task automatic send_spike_line(input int pw);
        for (int i = 0; i < 780; i++) begin
            if (i == 100 || i == 300 || (i >= 500 && i < 500 + pw)) step(sync_lvl());
            else step(blank_lvl());
        end
    endtask

    // 6 EQ, 6 broad, 6 EQ half-lines.
    task automatic send_vseq();
        for (int k = 0; k < 18; k++) begin
            cur_seg = k;
            send_line((k >= 6 && k < 12) ? 333 : 29, 390);
        end
    endtask

    typedef struct {
        int w;
        int len;
        int exp_hs;
        bit exp_lock;
    } line_vec_t;

    line_vec_t tbl[15];

    initial begin
        // Lines 1-4 lock; line 6 shifted +10; lines 11-14 without sync.
        tbl[0]  = '{58, 780, 1, 1'b0};
        tbl[1]  = '{58, 780, 1, 1'b0};
        tbl[2]  = '{58, 780, 1, 1'b0};
        tbl[3]  = '{58, 780, 1, 1'b1};
        tbl[4]  = '{58, 790, 1, 1'b1};
        tbl[5]  = '{58, 770, 0, 1'b1};
        tbl[6]  = '{58, 780, 1, 1'b1};
        tbl[7]  = '{58, 780, 1, 1'b1};
        tbl[8]  = '{58, 780, 1, 1'b1};
        tbl[9]  = '{58, 780, 1, 1'b1};
        tbl[10] = '{ 0, 780, 0, 1'b1};
        tbl[11] = '{ 0, 780, 0, 1'b1};
        tbl[12] = '{ 0, 780, 0, 1'b1};
        tbl[13] = '{ 0, 780, 0, 1'b1};
        tbl[14] = '{58, 780, 1, 1'b0};

        cur_seg = 0;
        clear_obs();
        model_reset();
        r_xarst = 1'b0;
        repeat (3) @(negedge r_clk);
        check_outputs("reset_state", 1'b0);
        r_xarst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            clear_obs();
            send_line(tbl[i].w, tbl[i].len);
            check_int($sformatf("tbl_hsync[%0d]", i), hs_cnt, tbl[i].exp_hs);
            if (tbl[i].exp_hs != 0) check_int($sformatf("tbl_hctr[%0d]", i), hs_hctr, 58);
            check_int($sformatf("tbl_lock[%0d]", i), int'(w_locked), int'(tbl[i].exp_lock));
        end

        // relock, then field-1 vertical interval aligned to the line start
        repeat (3) send_line(58, 780);
        check_int("relock", int'(w_locked), 1);
        clear_obs();
        send_vseq();
        check_int("f1_vsync_pos", vs_first_seg, 8);
        check_int("f1_field", vs_first_field, 0);
        check_int("f1_vctr", vs_first_vctr, 0);
        check_int("f1_vsync_cnt", vs_cnt, 2);

        // field-2: same sequence starting half a line later
        repeat (3) send_line(58, 780);
        send_line(0, 390);
        clear_obs();
        send_vseq();
        check_int("f2_vsync_pos", vs_first_seg, 8);
        check_int("f2_field", vs_first_field, 1);
        check_int("f2_vctr", vs_first_vctr, 0);

        // spikes and a W=10 pulse produce no HSYNC; W=10 clears BRCNT
        clear_obs();
        send_spike_line(10);
        check_int("spike_hsync", hs_cnt, 0);
        clear_obs();
        send_line(333, 390);
        send_line(333, 390);
        send_line(10, 390);
        send_line(333, 390);
        send_line(333, 390);
        check_int("brcnt_clear", vs_cnt, 0);
        send_line(333, 390);
        check_int("vsync_after_clear", vs_cnt, 1);

        // reset in the middle of a broad pulse
        for (int i = 0; i < 150; i++) step(sync_lvl());
        r_xarst = 1'b0;
        r_ck_ee = 1'b1;
        r_video = 10'd0;
        @(negedge r_clk);
        model_reset();
        check_outputs("reset_mid_broad", 1'b0);
        r_ck_ee = 1'b0;
        r_xarst = 1'b1;

        // randomized lines against the model
        noisy = 1;
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: send_line($urandom_range(50, 66), 777 + $urandom_range(0, 6));
                4:          begin send_line(29, 390); send_line(29, 390); end
                5:          begin send_line(333, 390); send_line(333, 390); end
                6:          send_spike_line($urandom_range(1, 250));
                default:    send_line(1100, 1200);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
